// File: rtl/pkg_match_monitor.sv
// pkg_match_monitor
// Registered pattern monitor for a sampled data bus. Each valid word is
// compared under a mask against a constant; a per-sample match flag, the
// current run of consecutive matches, a saturating total of matches and a
// sticky alarm (raised when a run reaches THRESHOLD) are registered.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_data carries a sample this cycle
//   in_data    sampled data word (WIDTH bits)
//   clear      synchronous clear of counters, state and alarm (beats in_valid)
//   match      registered: last accepted sample matched
//   run_len    consecutive-match count, saturating
//   hit_count  total matches since reset/clear, saturating
//   alarm      sticky: a run reached THRESHOLD
//   state      debug view of the FSM: 0 IDLE, 1 RUN, 2 ALARM
//   id_code    constant identification code
module pkg_match_monitor #(
  parameter int               WIDTH       = 6,
  parameter logic [WIDTH-1:0] MATCH_VALUE = WIDTH'(6'h03),
  parameter logic [WIDTH-1:0] MATCH_MASK  = '1,
  parameter int               CNT_WIDTH   = 4,
  parameter int               THRESHOLD   = 4,
  parameter logic [1:0]       ID_CODE     = 2'h1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 clear,
  output logic                 match,
  output logic [CNT_WIDTH-1:0] run_len,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic                 alarm,
  output logic [1:0]           state,
  output logic [1:0]           id_code
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    ALARM = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH:0]   THRESH_W = (CNT_WIDTH+1)'(THRESHOLD);

  state_t               state_reg, state_next;
  logic                 match_reg, match_next;
  logic                 alarm_reg, alarm_next;
  logic [CNT_WIDTH-1:0] run_len_reg, run_len_next;
  logic [CNT_WIDTH-1:0] hit_count_reg, hit_count_next;

  logic                 hit;
  logic [CNT_WIDTH:0]   run_inc;   // one bit wider so the threshold test never wraps
  logic [CNT_WIDTH-1:0] run_sat;
  logic [CNT_WIDTH-1:0] hit_sat;

  always_comb begin
    hit     = ((in_data ^ MATCH_VALUE) & MATCH_MASK) == '0;
    run_inc = {1'b0, run_len_reg} + {{CNT_WIDTH{1'b0}}, 1'b1};
    run_sat = (run_len_reg == CNT_MAX) ? CNT_MAX : run_len_reg + 1'b1;
    hit_sat = (hit_count_reg == CNT_MAX) ? CNT_MAX : hit_count_reg + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      match_reg     <= 1'b0;
      alarm_reg     <= 1'b0;
      run_len_reg   <= '0;
      hit_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      match_reg     <= match_next;
      alarm_reg     <= alarm_next;
      run_len_reg   <= run_len_next;
      hit_count_reg <= hit_count_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    match_next     = 1'b0;
    run_len_next   = run_len_reg;
    hit_count_next = hit_count_reg;

    if (clear) begin
      // The sample presented alongside clear is deliberately dropped.
      state_next     = IDLE;
      run_len_next   = '0;
      hit_count_next = '0;
    end else begin
      // Counters follow the live data in every state, including ALARM.
      if (in_valid) begin
        match_next = hit;
        if (hit) begin
          run_len_next   = run_sat;
          hit_count_next = hit_sat;
        end else begin
          run_len_next = '0;
        end
      end

      case (state_reg)
        IDLE, RUN: begin
          if (in_valid) begin
            if (!hit)                   state_next = IDLE;
            else if (run_inc >= THRESH_W) state_next = ALARM;
            else                        state_next = RUN;
          end
        end
        ALARM:   state_next = ALARM;
        default: state_next = IDLE;   // encoding 3 recovers on the next clock
      endcase
    end

    // Registered alongside the state so it rises on the same edge as run_len.
    alarm_next = (state_next == ALARM);
  end

  assign match     = match_reg;
  assign run_len   = run_len_reg;
  assign hit_count = hit_count_reg;
  assign alarm     = alarm_reg;
  assign state     = state_reg;
  assign id_code   = ID_CODE;

endmodule
